// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: 4-entry FIFO feeding a controller via a start/waiting handshake.
// Latency: push at edge k into an empty FIFO pops at k+1; ctrl_start is high between k+1 and k+2.
// Backpressure: in_ready = (fifo_count < 4) regardless of a same-cycle pop; a rejected push must be held by the producer.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_instr/in_ready  producer push interface
//   ctrl_waiting             controller idle flag; ctrl_start one-cycle issue pulse
//   ctrl_instr, opcode, ALU_op, shift_op  held copy of the issued instruction and its fields
//   fifo_count, issued_count, ack_err, idle  status

// Small synchronous FIFO with power-of-two depth. Storage is not reset;
// pointers and count are. push_rdy depends only on the current count.
module dispatch_fifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [W-1:0]  mem [1 << AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  assign push_rdy  = (count < DEPTH);
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && (count != '0);
  assign pop_dat   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)      count <= count + 1'b1;
      else if (pop_fire && !push_fire) count <= count - 1'b1;
    end
  end
endmodule

module inst_dispatcher (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        ctrl_waiting,
  output logic        ctrl_start,
  output logic [15:0] ctrl_instr,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  fifo_count,
  output logic [7:0]  issued_count,
  output logic        ack_err,
  output logic        idle
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ack_cnt_q, ack_cnt_d;
  logic        pop;
  logic        set_err;
  logic        inc_issued;
  logic [15:0] head_dat;

  dispatch_fifo #(.W(16), .AW(2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_dat (in_instr),
    .push_rdy (in_ready),
    .pop_vld  (pop),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    pop        = 1'b0;
    set_err    = 1'b0;
    inc_issued = 1'b0;
    ctrl_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != 3'd0 && ctrl_waiting) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ctrl_start = 1'b1;
        ack_cnt_d  = 2'd0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The controller acknowledges start by dropping waiting; give up
        // once the counter has seen waiting stay high at count 3.
        if (!ctrl_waiting) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == 2'd3) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (ctrl_waiting) begin
          inc_issued = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_cnt_q    <= 2'd0;
      ctrl_instr   <= 16'h0000;
      issued_count <= 8'd0;
      ack_err      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      if (pop)        ctrl_instr   <= head_dat;
      if (inc_issued) issued_count <= issued_count + 8'd1;
      if (set_err)    ack_err      <= 1'b1;
    end
  end

  assign opcode   = ctrl_instr[15:13];
  assign ALU_op   = ctrl_instr[12:11];
  assign shift_op = ctrl_instr[4:3];
  assign idle     = (state_q == IDLE) && (fifo_count == 3'd0) && ctrl_waiting;
endmodule
